// File: rtl/masked_subbytes_seq.sv
// Byte-serial sequencer around an external masked, pipelined AES S-box: feeds one shared
// byte per cycle, writes the S-box results back in place and returns the shared SubBytes state.
module masked_subbytes_seq #(
   parameter int SHARES   = 2,
   parameter int SBOX_LAT = 4
) (
   input  logic                    ClkxCI,
   input  logic                    RstxBI,
   input  logic [128*SHARES-1:0]   StatexDI,
   input  logic                    InValidxSI,
   output logic                    InReadyxSO,
   output logic [128*SHARES-1:0]   StatexDO,
   output logic                    OutValidxSO,
   input  logic                    OutReadyxSI,
   output logic [8*SHARES-1:0]     SboxInxDO,
   input  logic [8*SHARES-1:0]     SboxOutxDI,
   output logic                    RandEnxSO,
   output logic                    BusyxSO
);

   localparam int SW = 128 * SHARES;

   if (SHARES < 2) begin : g_bad_shares
      $error("masked_subbytes_seq: SHARES must be at least 2");
   end
   if (SBOX_LAT < 1) begin : g_bad_lat
      $error("masked_subbytes_seq: SBOX_LAT must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fsm_e;

   fsm_e                fsm_q, fsm_d;
   logic [3:0]          feed_cnt_q, feed_cnt_d;
   logic [3:0]          cap_cnt_q, cap_cnt_d;
   logic [SBOX_LAT-1:0] tag_q, tag_d;
   logic [SW-1:0]       state_q, state_d;

   logic                load;
   logic                feed;
   logic                capture;

   // Control: one byte enters the S-box per FEED cycle; a tag marks it through the pipeline.
   always_comb begin : fsm_comb
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      fsm_d       = fsm_q;
      feed_cnt_d  = feed_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      load        = 1'b0;
      feed        = 1'b0;
      capture     = tag_q[SBOX_LAT-1];
      InReadyxSO  = 1'b0;
      OutValidxSO = 1'b0;
      RandEnxSO   = 1'b0;
      BusyxSO     = 1'b0;

      if (capture) begin
         cap_cnt_d = cap_cnt_q + 4'd1;
      end

      case (fsm_q)
         IDLE: begin
            InReadyxSO = 1'b1;
            if (InValidxSI) begin
               load       = 1'b1;
               feed_cnt_d = 4'd0;
               cap_cnt_d  = 4'd0;
               fsm_d      = FEED;
            end
         end
         FEED: begin
            feed       = 1'b1;
            RandEnxSO  = 1'b1;
            BusyxSO    = 1'b1;
            feed_cnt_d = feed_cnt_q + 4'd1;
            if (feed_cnt_q == 4'd15) begin
               fsm_d = DRAIN;
            end
         end
         DRAIN: begin
            BusyxSO = 1'b1;
            if (capture && (cap_cnt_q == 4'd15)) begin
               fsm_d = DONE;
            end
         end
         DONE: begin
            OutValidxSO = 1'b1;
            if (OutReadyxSI) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_comb begin : tag_comb
      tag_d[0] = feed;
      for (int j = 1; j < SBOX_LAT; j++) begin
         tag_d[j] = tag_q[j-1];
      end
   end

   // Share-wise datapath: each share's byte lane is selected and written independently.
   always_comb begin : state_comb
      state_d = state_q;
      if (load) begin
         state_d = StatexDI;
      end else if (capture) begin
         for (int i = 0; i < SHARES; i++) begin
            state_d[128*i + 8*int'(cap_cnt_q) +: 8] = SboxOutxDI[8*i +: 8];
         end
      end
   end

   always_comb begin : sbox_in_comb
      SboxInxDO = '0;
      if (fsm_q == FEED) begin
         for (int i = 0; i < SHARES; i++) begin
            SboxInxDO[8*i +: 8] = state_q[128*i + 8*int'(feed_cnt_q) +: 8];
         end
      end
   end

   assign StatexDO = (fsm_q == DONE) ? state_q : '0;

   always_ff @(posedge ClkxCI or negedge RstxBI) begin : ctrl_ff
      if (!RstxBI) begin
         fsm_q      <= IDLE;
         feed_cnt_q <= 4'd0;
         cap_cnt_q  <= 4'd0;
         tag_q      <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge value of its neighbours.
         fsm_q      <= fsm_d;
         feed_cnt_q <= feed_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         tag_q      <= tag_d;
      end
   end

   // NOTE: the shared state register has no reset; it is only exposed in DONE, after a full reload.
   always_ff @(posedge ClkxCI) begin : state_ff
      state_q <= state_d;
   end

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Bench for masked_subbytes_seq: SHARES=2 and SHARES=3 instances run side by side, each with a
// behavioural 4-edge masked S-box model; results are recombined and compared to hand-computed vectors.
module tb_masked_subbytes_seq;

   localparam int LAT = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;

   logic [255:0] st_in2, st_out2;
   logic [383:0] st_in3, st_out3;
   logic [15:0]  sbin2, sbout2;
   logic [23:0]  sbin3, sbout3;
   logic         inrdy2, ov2, ren2, busy2;
   logic         inrdy3, ov3, ren3, busy3;

   int           n_pass  = 0;
   int           n_total = 0;

   typedef struct {
      string        name;
      logic [127:0] plain;
      logic [127:0] expected;
   } vec_t;

   always #5 clk = ~clk;

   masked_subbytes_seq #(.SHARES(2), .SBOX_LAT(LAT)) u_dut2 (
      .ClkxCI      (clk),
      .RstxBI      (rst_n),
      .StatexDI    (st_in2),
      .InValidxSI  (in_valid),
      .InReadyxSO  (inrdy2),
      .StatexDO    (st_out2),
      .OutValidxSO (ov2),
      .OutReadyxSI (out_ready),
      .SboxInxDO   (sbin2),
      .SboxOutxDI  (sbout2),
      .RandEnxSO   (ren2),
      .BusyxSO     (busy2)
   );

   masked_subbytes_seq #(.SHARES(3), .SBOX_LAT(LAT)) u_dut3 (
      .ClkxCI      (clk),
      .RstxBI      (rst_n),
      .StatexDI    (st_in3),
      .InValidxSI  (in_valid),
      .InReadyxSO  (inrdy3),
      .StatexDO    (st_out3),
      .OutValidxSO (ov3),
      .OutReadyxSI (out_ready),
      .SboxInxDO   (sbin3),
      .SboxOutxDI  (sbout3),
      .RandEnxSO   (ren3),
      .BusyxSO     (busy3)
   );

   // ---------------- AES S-box reference (GF(2^8) inverse + affine map) ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] aes_sbox(input logic [7:0] x);
      logic [7:0] inv, b;
      inv = 8'h01;
      b   = x;
      // x^254 = x^2 * x^4 * ... * x^128
      for (int k = 0; k < 7; k++) begin
         b   = gmul(b, b);
         inv = gmul(inv, b);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [15:0] reshare2(input logic [15:0] x, input logic [7:0] r);
      return {r, aes_sbox(x[7:0] ^ x[15:8]) ^ r};
   endfunction

   function automatic logic [23:0] reshare3(input logic [23:0] x, input logic [15:0] r);
      return {r[15:8], r[7:0], aes_sbox(x[7:0] ^ x[15:8] ^ x[23:16]) ^ r[7:0] ^ r[15:8]};
   endfunction

   function automatic logic [127:0] recomb2(input logic [255:0] s);
      return s[127:0] ^ s[255:128];
   endfunction

   function automatic logic [127:0] recomb3(input logic [383:0] s);
      return s[127:0] ^ s[255:128] ^ s[383:256];
   endfunction

   // External S-box models: never reset, so stale pipeline contents keep flowing after a reset.
   logic [15:0] sb2_pipe [LAT];
   logic [23:0] sb3_pipe [LAT];

   always_ff @(posedge clk) begin
      sb2_pipe[0] <= reshare2(sbin2, 8'($urandom));
      sb3_pipe[0] <= reshare3(sbin3, 16'($urandom));
      for (int j = 1; j < LAT; j++) begin
         sb2_pipe[j] <= sb2_pipe[j-1];
         sb3_pipe[j] <= sb3_pipe[j-1];
      end
   end

   assign sbout2 = sb2_pipe[LAT-1];
   assign sbout3 = sb3_pipe[LAT-1];

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_state(input logic [127:0] plain);
      logic [127:0] m1, m2;
      m1     = {$urandom, $urandom, $urandom, $urandom};
      m2     = {$urandom, $urandom, $urandom, $urandom};
      st_in2 = {m1, plain ^ m1};
      st_in3 = {m2, m1, plain ^ m1 ^ m2};
   endtask

   task automatic check_quiet(input string name);
      check({name, " inready"}, {inrdy2, inrdy3}, 2'b11);
      check({name, " valid/randen/busy"}, {ov2, ren2, busy2, ov3, ren3, busy3}, 6'b0);
      check({name, " sbox inputs"}, {sbin2, sbin3}, 40'h0);
      check({name, " state outputs"}, {127'h0, (|st_out2) | (|st_out3)}, 128'h0);
   endtask

   task automatic idle_hygiene(input string name, input int n);
      int bad;
      bad = 0;
      repeat (n) begin
         @(negedge clk);
         if (sbin2 != 0 || sbin3 != 0 || ren2 || ren3 || busy2 || busy3 ||
             st_out2 != 0 || st_out3 != 0 || !inrdy2 || !inrdy3) bad++;
      end
      check({name, " bad idle cycles"}, bad, 0);
   endtask

   // One full transaction; optional DONE backpressure and an InValid pulse during FEED.
   task automatic run_txn(input string name, input logic [127:0] plain, input logic [127:0] exp,
                          input int hold, input bit do_pulse, input logic [127:0] other);
      int edges, r2, r3, b2, cyc, bad;
      @(negedge clk);
      check({name, " inready before accept"}, {inrdy2, inrdy3}, 2'b11);
      drive_state(plain);
      in_valid = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      in_valid = 1'b0;
      r2 = 0; r3 = 0; b2 = 0; cyc = 0;
      while (!(ov2 && ov3) && edges < 60) begin
         if (ren2) r2++;
         if (ren3) r3++;
         if (busy2) b2++;
         if (do_pulse && cyc == 3) begin
            check({name, " inready in FEED"}, {inrdy2, inrdy3}, 2'b00);
            drive_state(other);
            in_valid = 1'b1;
         end
         @(posedge clk);
         edges++;
         @(negedge clk);
         in_valid = 1'b0;
         cyc++;
      end
      check({name, " latency edges incl accept"}, edges, 21);
      check({name, " randen cycles s2"}, r2, 16);
      check({name, " randen cycles s3"}, r3, 16);
      check({name, " busy cycles"}, b2, 20);
      check({name, " result s2"}, recomb2(st_out2), exp);
      check({name, " result s3"}, recomb3(st_out3), exp);
      check({name, " inready in DONE"}, {inrdy2, inrdy3}, 2'b00);
      bad = 0;
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         if (recomb2(st_out2) !== exp || recomb3(st_out3) !== exp ||
             !ov2 || !ov3 || inrdy2 || inrdy3) bad++;
      end
      if (hold > 0) check({name, " backpressure bad cycles"}, bad, 0);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " back to IDLE"}, {ov2, ov3, inrdy2, inrdy3}, 4'b0011);
      check({name, " state cleared after DONE"}, {127'h0, (|st_out2) | (|st_out3)}, 128'h0);
   endtask

   // ---------------- test sequence ----------------
   localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
   localparam logic [127:0] ALL_63   = 128'h63636363636363636363636363636363;
   localparam logic [127:0] ALL_FF   = 128'hffffffffffffffffffffffffffffffff;
   localparam logic [127:0] ALL_16   = 128'h16161616161616161616161616161616;
   localparam logic [127:0] ABORT_IN = 128'hfedcba98765432100123456789abcdef;

   initial begin
      vec_t vecs [5];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      st_in2    = '0;
      st_in3    = '0;

      vecs[0] = '{"single byte", 128'h00000000000000000000000000000053,
                  128'h636363636363636363636363636363ed};
      vecs[1] = '{"fips197", FIPS_IN, FIPS_OUT};
      vecs[2] = '{"all zero", 128'h0, ALL_63};
      vecs[3] = '{"all 01", 128'h01010101010101010101010101010101,
                  128'h7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c7c};
      vecs[4] = '{"all ff", ALL_FF, ALL_16};

      #12;
      check_quiet("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < 5; v++) begin
         run_txn(vecs[v].name, vecs[v].plain, vecs[v].expected, 0, 1'b0, 128'h0);
      end

      run_txn("backpressure", FIPS_IN, FIPS_OUT, 10, 1'b0, 128'h0);
      run_txn("ignored input", FIPS_IN, FIPS_OUT, 0, 1'b1, ALL_FF);
      run_txn("second state", ALL_FF, ALL_16, 0, 1'b0, 128'h0);

      // Abort at feed byte 7, then start a fresh all-zero state right after reset release.
      @(negedge clk);
      drive_state(ABORT_IN);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (7) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("abort sbox byte7 s2", sbin2[7:0] ^ sbin2[15:8], 8'h01);
      check("abort sbox byte7 s3", sbin3[7:0] ^ sbin3[15:8] ^ sbin3[23:16], 8'h01);
      #1 rst_n = 1'b0;
      #1 check_quiet("mid-feed reset");
      #1 rst_n = 1'b1;
      run_txn("after abort", 128'h0, ALL_63, 0, 1'b0, 128'h0);

      idle_hygiene("idle", 50);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
